sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Serial-in parallel-out receiver that sits directly downstream of the 4-bit parallel-in serial-out shifter. It collects one bit per qualified clock and assembles WIDTH-bit words. It presents each completed word on a registered valid/ready output buffer. It detects and flags words lost when the consumer stalls.

Parameters:
WIDTH, 4, word width in bits; legal values 2..32
MSB_FIRST, 1, 1: first received bit lands in pout[WIDTH-1]; 0: first received bit lands in pout[0]

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
sin  input  1  serial data bit
sin_en  input  1  bit strobe; sin sampled only when 1
sync_clr  input  1  frame align; discards any partial word
pout  output  WIDTH  assembled word (output buffer)
pout_valid  output  1  pout holds an unconsumed word
pout_ready  input  1  consumer accepts pout when pout_valid=1
busy  output  1  partial word in progress (bit count != 0)
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun

Behaviour:
- Reset (rst_n=0, asynchronous): shift reg=0, bit count=0, pout=0, pout_valid=0, busy=0, overrun=0. Reset mid-word discards the partial word and any buffered word.
- Bit capture: on a rising edge with sin_en=1, shift sin in.
  - MSB_FIRST=1: shift left, sin enters at bit 0.
  - MSB_FIRST=0: shift right, sin enters at bit WIDTH-1.
  - The bit count increments, modulo WIDTH. Count register width is clog2(WIDTH).
- Word completion: the edge that accepts the WIDTH-th bit also loads the full word, including that bit, into pout, and sets pout_valid. Latency: pout_valid=1 in the cycle after the last bit's sampling edge. The count wraps to 0 and the next bit starts a new word with no dead cycle.
- Handshake:
  - Transfer occurs on an edge with pout_valid=1 and pout_ready=1.
  - pout and pout_valid are held stable while pout_valid=1 and pout_ready=0.
  - pout_ready is ignored when pout_valid=0.
  - pout_valid clears after a transfer unless a new word completes on that same edge.
- Simultaneous completion and transfer: the new word loads and pout_valid stays 1 (back-to-back words at full rate, no loss).
- Overrun: if a word completes on an edge where pout_valid=1 and pout_ready=0:
  - the new word is dropped;
  - pout keeps the old word;
  - overrun is set.
  - overrun stays 1 until an edge with ovr_clr=1. If set and clear coincide, set wins.
- sync_clr: the bit count returns to 0 and the partial word is discarded. pout, pout_valid and overrun are unaffected. If sync_clr and sin_en are both 1, the sampled bit becomes bit 1 of the new word (count becomes 1).
- busy is registered and equals (bit count != 0).
- sin_en=0: no state change in the shift path. Gaps between bits of any length are allowed.

Decomposition:
- Shared package serdes_pkg holds:
  - the default word width constant (4), shared with the serializer;
  - the count-width helper (clog2);
  - the MSB_FIRST/LSB_FIRST order constants.
- One natural sub-module: sipo_out_buf, the single-entry valid/ready holding register with overrun detection. The shift register and bit counter remain in the top.

Test Plan:
- Reset: assert rst_n=0 mid-word after 2 bits, then release → pout=0, pout_valid=0, busy=0, overrun=0. The next 4 bits 1,0,1,1 give pout=4'b1011.
- MSB_FIRST=1, pout_ready=1: bits 1,0,1,0 on consecutive sin_en cycles → pout=4'hA, pout_valid=1 for exactly one cycle, one cycle after the 4th bit. Repeat with MSB_FIRST=0 and the same bits → pout=4'h5.
- Gapped strobes: bits 1,1,0,0 with sin_en low 3 cycles between each → pout=4'hC; busy=1 from the first bit until completion.
- Back-to-back: stream 4'h3 then 4'h9 continuously with pout_ready=1 → two transfers, pout_valid high on both completion cycles, overrun=0.
- Stall/overrun: pout_ready=0, send 4'h6 then 4'hF → pout stays 4'h6, overrun=1. Raise pout_ready → 4'h6 transfers and pout_valid=0. Pulse ovr_clr → overrun=0. Also assert ovr_clr on the same edge as a new overrun → overrun=1.
- sync_clr: send 2 bits, then sync_clr with sin_en=1 and sin=1, then bits 0,0,1 → pout=4'b1001, with no word emitted for the discarded partial.

Source files
------------

// File: rtl/serdes_pkg.sv
// Constants and helpers shared by the serializer/deserializer pair.
package serdes_pkg;
  localparam int SERDES_WIDTH    = 4;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  // A count register needs at least one bit even for the smallest word.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready output register. A word arriving while the entry is
// held by a stalled consumer is dropped and flagged in a sticky overrun bit.
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             drop;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop    = load_i & valid_q & ~ready_i;
    if (load_i && !drop) begin
      data_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A new drop takes priority over a clear on the same edge.
    if (drop)           ovr_d = 1'b1;
    else if (ovr_clr_i) ovr_d = 1'b0;
    else                ovr_d = ovr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;
endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from strobed
// serial bits and hands them off through a valid/ready output buffer.
module sipo_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = SERDES_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d, shift_base;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic             busy_q;
  logic             word_done;

  always_comb begin
    // sync_clr restarts the frame; a bit strobed on the same edge becomes bit 1.
    shift_base = sync_clr ? '0 : shift_q;
    cnt_base   = sync_clr ? '0 : cnt_q;
    shift_d    = shift_base;
    cnt_d      = cnt_base;
    word_done  = 1'b0;
    if (sin_en) begin
      if (MSB_FIRST) shift_d = {shift_base[WIDTH-2:0], sin};
      else           shift_d = {sin, shift_base[WIDTH-1:1]};
      word_done = (cnt_base == LAST);
      cnt_d     = word_done ? '0 : cnt_base + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      busy_q  <= (cnt_d != '0);
    end
  end

  assign busy = busy_q;

  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (word_done),
    .word_i    (shift_d),
    .ready_i   (pout_ready),
    .ovr_clr_i (ovr_clr),
    .data_o    (pout),
    .valid_o   (pout_valid),
    .overrun_o (overrun)
  );
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed scenarios plus randomized traffic against a bit-queue reference
// model; one MSB-first and one LSB-first instance see identical stimulus.
module tb_sipo_deserializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n, sin, sin_en, sync_clr, pout_ready, ovr_clr;
  logic [W-1:0] pout_m, pout_l;
  logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit           mq[$];
  logic [W-1:0] m_pm, m_pl;
  bit           m_valid, m_ovr, m_busy;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sync_clr(sync_clr),
    .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready),
    .busy(busy_m), .overrun(ovr_m), .ovr_clr(ovr_clr));

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en), .sync_clr(sync_clr),
    .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready),
    .busy(busy_l), .overrun(ovr_l), .ovr_clr(ovr_clr));

  task automatic model_reset();
    mq.delete();
    m_pm = '0; m_pl = '0; m_valid = 0; m_ovr = 0; m_busy = 0;
  endtask

  // Drive one clock of stimulus and advance the model across the same edge.
  task automatic cycle(input bit en, input bit b, input bit sc, input bit rdy, input bit oc);
    logic [W-1:0] wm, wl;
    bit done, drop;
    sin_en = en; sin = b; sync_clr = sc; pout_ready = rdy; ovr_clr = oc;
    @(posedge clk);
    done = 0; wm = '0; wl = '0;
    if (sc) mq.delete();
    if (en) begin
      mq.push_back(b);
      if (mq.size() == W) begin
        done = 1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mq[i];
          wl[i]     = mq[i];
        end
        mq.delete();
      end
    end
    drop = done && m_valid && !rdy;
    if (done && !drop) begin
      m_pm = wm; m_pl = wl; m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1;
    else if (oc) m_ovr = 0;
    m_busy = (mq.size() != 0);
    #1;
    sin_en = 0; sin = 0; sync_clr = 0; ovr_clr = 0;
  endtask

  task automatic send_word(input logic [3:0] bits_in_order, input bit rdy);
    logic [3:0] v;
    v = bits_in_order;
    for (int i = 3; i >= 0; i--) cycle(1, v[i], 0, rdy, 0);
  endtask

  task automatic test_reset();
    rst_n = 0; sin = 0; sin_en = 0; sync_clr = 0; pout_ready = 0; ovr_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({pout_m, valid_m, busy_m, ovr_m} !== 7'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0000000", {pout_m, valid_m, busy_m, ovr_m}); end
    rst_n = 1;
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    n_cmp++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: got %b want 1", busy_m); end
    #3 rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if ({pout_m, valid_m, busy_m, ovr_m} !== 7'b0) begin n_fail++; $display("FAIL midword_reset: got %b want 0000000", {pout_m, valid_m, busy_m, ovr_m}); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    send_word(4'b1011, 1);
    n_cmp++; if (pout_m !== 4'b1011 || valid_m !== 1'b1) begin n_fail++; $display("FAIL reset_next_word: got %h/%b want b/1", pout_m, valid_m); end
    n_cmp++; if (pout_l !== 4'b1101) begin n_fail++; $display("FAIL reset_next_word_lsb: got %h want d", pout_l); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_bit_order();
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    n_cmp++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b want 0", valid_m); end
    cycle(1, 0, 0, 1, 0);
    n_cmp++; if (pout_m !== 4'hA || valid_m !== 1'b1) begin n_fail++; $display("FAIL msb_first_word: got %h/%b want a/1", pout_m, valid_m); end
    n_cmp++; if (pout_l !== 4'h5 || valid_l !== 1'b1) begin n_fail++; $display("FAIL lsb_first_word: got %h/%b want 5/1", pout_l, valid_l); end
    cycle(0, 0, 0, 1, 0);
    n_cmp++; if (valid_m !== 1'b0 || valid_l !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b%b want 00", valid_m, valid_l); end
  endtask

  task automatic test_gapped();
    logic [3:0] v;
    int busy_bad;
    v = 4'b1100; busy_bad = 0;
    for (int i = 3; i >= 0; i--) begin
      cycle(1, v[i], 0, 1, 0);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          if (busy_m !== 1'b1) busy_bad++;
          cycle(0, 0, 0, 0, 0);
        end
        if (busy_m !== 1'b1) busy_bad++;
      end
    end
    n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL gapped_busy: got %0d low samples want 0", busy_bad); end
    n_cmp++; if (pout_m !== 4'hC || valid_m !== 1'b1 || busy_m !== 1'b0) begin n_fail++; $display("FAIL gapped_word: got %h/%b/%b want c/1/0", pout_m, valid_m, busy_m); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int xfers;
    logic [7:0] s;
    s = 8'h39; xfers = 0;
    for (int i = 7; i >= 0; i--) begin
      cycle(1, s[i], 0, 1, 0);
      if (valid_m) xfers++;
      if (i == 4) begin
        n_cmp++; if (pout_m !== 4'h3 || valid_m !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 3/1", pout_m, valid_m); end
      end
    end
    n_cmp++; if (pout_m !== 4'h9 || valid_m !== 1'b1 || ovr_m !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got %h/%b/%b want 9/1/0", pout_m, valid_m, ovr_m); end
    n_cmp++; if (xfers != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", xfers); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    send_word(4'h6, 0);
    send_word(4'hF, 0);
    n_cmp++; if (pout_m !== 4'h6 || valid_m !== 1'b1 || ovr_m !== 1'b1) begin n_fail++; $display("FAIL overrun_hold: got %h/%b/%b want 6/1/1", pout_m, valid_m, ovr_m); end
    cycle(0, 0, 0, 1, 0);
    n_cmp++; if (valid_m !== 1'b0 || ovr_m !== 1'b1 || pout_m !== 4'h6) begin n_fail++; $display("FAIL overrun_drain: got %h/%b/%b want 6/0/1", pout_m, valid_m, ovr_m); end
    cycle(0, 0, 0, 0, 1);
    n_cmp++; if (ovr_m !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr_m); end
    send_word(4'hA, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    n_cmp++; if (ovr_m !== 1'b1 || pout_m !== 4'hA) begin n_fail++; $display("FAIL set_beats_clear: got %h/%b want a/1", pout_m, ovr_m); end
    cycle(0, 0, 0, 1, 1);
  endtask

  task automatic test_sync_clr();
    int early;
    early = 0;
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 1, 1, 0);
    if (valid_m) early++;
    n_cmp++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL sync_busy: got %b want 1", busy_m); end
    cycle(1, 0, 0, 1, 0); if (valid_m) early++;
    cycle(1, 0, 0, 1, 0); if (valid_m) early++;
    cycle(1, 1, 0, 1, 0);
    n_cmp++; if (early != 0) begin n_fail++; $display("FAIL sync_no_partial: got %0d words want 0", early); end
    n_cmp++; if (pout_m !== 4'b1001 || valid_m !== 1'b1) begin n_fail++; $display("FAIL sync_word: got %h/%b want 9/1", pout_m, valid_m); end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(99) < 70, 1'($urandom), $urandom_range(99) < 5,
            $urandom_range(99) < 60, $urandom_range(99) < 10);
      n_cmp++;
      if ({pout_m, valid_m, busy_m, ovr_m, pout_l, valid_l, busy_l, ovr_l} !==
          {m_pm, m_valid, m_busy, m_ovr, m_pl, m_valid, m_busy, m_ovr}) begin
        n_fail++;
        if (bad < 5) $display("FAIL random_cyc%0d: got m=%h/%b%b%b l=%h/%b%b%b want m=%h l=%h v%b b%b o%b",
          i, pout_m, valid_m, busy_m, ovr_m, pout_l, valid_l, busy_l, ovr_l, m_pm, m_pl, m_valid, m_busy, m_ovr);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_sync_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
